// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART string transmitter arbiter: FSM state encoding,
// default payload size, frame delimiter and the length clamp helper.
package uart_arb_pkg;

  typedef enum logic [3:0] {
    ARB_IDLE      = 4'b0001,
    ARB_ISSUE     = 4'b0010,
    ARB_WAIT_DONE = 4'b0100,
    ARB_DONE      = 4'b1000
  } arb_state_t;

  localparam int         ARB_MAX_BYTES = 137;
  localparam logic [7:0] ARB_DELIM     = 8'h26;  // '&', framing byte emitted by the transmitter

  function automatic logic [7:0] clamp_len(input logic [7:0] len, input int max_bytes);
    return (int'(len) > max_bytes) ? 8'(max_bytes) : len;
  endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin pick: first pending index at or after rr_ptr, wrapping.
module rr_arbiter_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_valid
);

  logic [NUM_REQ-1:0] rotated;
  logic [IDX_W:0]     sum;

  // Rotate so that bit 0 corresponds to the rr pointer position.
  assign rotated = NUM_REQ'({pending, pending} >> rr_ptr);

  // Scanning downwards lets the lowest rotated offset win without a break.
  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    sum       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
        if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
          sum = sum - (IDX_W + 1)'(NUM_REQ);
        end
        win_idx   = sum[IDX_W-1:0];
        win_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_string_tx_arbiter.sv
// Round-robin sharing of one string UART transmitter among NUM_REQ requesters.
// Optional watchdog in WAIT_DONE enabled by macro UART_ARB_TIMEOUT_EN.
module uart_string_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BYTES = ARB_MAX_BYTES
`ifdef UART_ARB_TIMEOUT_EN
  ,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
`endif
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*MAX_BYTES*8-1:0] req_string,
  input  logic [NUM_REQ*8-1:0]           req_length,
  output logic [NUM_REQ-1:0]             req_pending,
  output logic [NUM_REQ-1:0]             req_done,
  output logic [MAX_BYTES*8-1:0]         str_tx_string,
  output logic [7:0]                     str_tx_length,
  output logic                           str_tx_req,
  input  logic                           str_tx_busy,
  input  logic                           str_tx_done,
  output logic [$clog2(NUM_REQ)-1:0]     grant_idx,
  output logic                           timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int STR_W = MAX_BYTES * 8;

  arb_state_t         state_reg, state_next;
  logic [NUM_REQ-1:0] pending_reg, pending_next, grant_onehot;
  logic [IDX_W-1:0]   grant_reg, rr_reg, win_idx;
  logic [7:0]         length_reg;
  logic               win_valid;
  logic               finish;
  logic               timeout_hit;
  logic [STR_W-1:0]   str_arr [NUM_REQ];
  logic [7:0]         len_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign str_arr[gi]      = req_string[gi*STR_W +: STR_W];
      assign len_arr[gi]      = req_length[gi*8 +: 8];
      assign grant_onehot[gi] = (grant_reg == IDX_W'(gi));
    end
  endgenerate

  rr_arbiter_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .pending   (pending_reg),
    .rr_ptr    (rr_reg),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

`ifdef UART_ARB_TIMEOUT_EN
  logic [23:0] wd_cnt_reg;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wd_cnt_reg <= '0;
    end else if (state_reg == ARB_WAIT_DONE) begin
      wd_cnt_reg <= wd_cnt_reg + 24'd1;
    end else begin
      wd_cnt_reg <= '0;
    end
  end

  assign timeout_hit = (state_reg == ARB_WAIT_DONE) && (wd_cnt_reg == TIMEOUT_CYCLES);
`else
  assign timeout_hit = 1'b0;
`endif

  assign timeout_err = timeout_hit;

  always_comb begin
    state_next = state_reg;
    str_tx_req = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (win_valid) state_next = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        if (!str_tx_busy) begin
          str_tx_req = 1'b1;
          state_next = ARB_WAIT_DONE;
        end
      end
      ARB_WAIT_DONE: begin
        // Watchdog expiry finishes the grant directly; a late done is then ignored.
        if (timeout_hit) begin
          finish     = 1'b1;
          state_next = ARB_IDLE;
        end else if (str_tx_done) begin
          state_next = ARB_DONE;
        end
      end
      ARB_DONE: begin
        finish     = 1'b1;
        state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // A new request arriving on the completion cycle survives the clear.
  assign pending_next = (pending_reg & ~(finish ? grant_onehot : '0)) | req_valid;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg   <= ARB_IDLE;
      pending_reg <= '0;
      grant_reg   <= '0;
      rr_reg      <= '0;
      length_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      if (state_reg == ARB_IDLE && win_valid) begin
        grant_reg  <= win_idx;
        length_reg <= clamp_len(len_arr[win_idx], MAX_BYTES);
      end
      if (finish) begin
        rr_reg <= (grant_reg == IDX_W'(NUM_REQ - 1)) ? '0 : grant_reg + IDX_W'(1);
      end
    end
  end

  assign req_pending   = pending_reg;
  assign req_done      = finish ? grant_onehot : '0;
  assign grant_idx     = grant_reg;
  assign str_tx_length = length_reg;
  assign str_tx_string = str_arr[grant_reg];

endmodule

// File: tb/tb_uart_string_tx_arbiter.sv
// Directed bench for uart_string_tx_arbiter; the transmitter side is driven by hand.
module tb_uart_string_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int MAX_BYTES = 137;
  localparam int STR_W     = MAX_BYTES * 8;

  logic                       sys_clk = 1'b0;
  logic                       sys_rst = 1'b1;
  logic [NUM_REQ-1:0]         req_valid = '0;
  logic [NUM_REQ*STR_W-1:0]   req_string = '0;
  logic [NUM_REQ*8-1:0]       req_length = '0;
  logic [NUM_REQ-1:0]         req_pending;
  logic [NUM_REQ-1:0]         req_done;
  logic [STR_W-1:0]           str_tx_string;
  logic [7:0]                 str_tx_length;
  logic                       str_tx_req;
  logic                       str_tx_busy = 1'b0;
  logic                       str_tx_done = 1'b0;
  logic [1:0]                 grant_idx;
  logic                       timeout_err;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  uart_string_tx_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .MAX_BYTES (MAX_BYTES)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (24'd100)
`endif
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .req_valid     (req_valid),
    .req_string    (req_string),
    .req_length    (req_length),
    .req_pending   (req_pending),
    .req_done      (req_done),
    .str_tx_string (str_tx_string),
    .str_tx_length (str_tx_length),
    .str_tx_req    (str_tx_req),
    .str_tx_busy   (str_tx_busy),
    .str_tx_done   (str_tx_done),
    .grant_idx     (grant_idx),
    .timeout_err   (timeout_err)
  );

  always @(negedge sys_clk) begin
    if (!sys_rst && str_tx_req) $display("TX   grant=%0d len=%0d", grant_idx, str_tx_length);
    if (|req_done) $display("DONE mask=%b timeout=%0b", req_done, timeout_err);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse(input logic [NUM_REQ-1:0] mask);
    req_valid = mask;
    tick();
    req_valid = '0;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    tick();
  endtask

  // Waits for the grant, plays one transmitter frame, optionally re-requests on the done cycle.
  task automatic serve(input int exp_grant, input int exp_len, input int lat,
                       input logic [NUM_REQ-1:0] rereq);
    int n = 0;
    while (str_tx_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("tx_req_seen", 64'(n < 50), 64'd1);
    check("grant", 64'(grant_idx), 64'(exp_grant));
    check("length", 64'(str_tx_length), 64'(exp_len));
    check("string_top", 64'(str_tx_string[STR_W-1 -: 8]), 64'(8'hA0 + exp_grant));
    tick();
    str_tx_busy = 1'b1;
    #1;
    check("tx_req_one_cycle", 64'(str_tx_req), 64'd0);
    repeat (lat) tick();
    str_tx_busy = 1'b0;
    str_tx_done = 1'b1;
    tick();
    str_tx_done = 1'b0;
    req_valid   = rereq;
    #1;
    check("done_pulse", 64'(req_done), 64'(4'b0001 << exp_grant));
    tick();
    req_valid = '0;
    #1;
    check("done_clear", 64'(req_done), 64'd0);
    check("pending_after", 64'(req_pending[exp_grant]), 64'(rereq[exp_grant]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic seen;
    logic [39:0] hello;
    int n;
    hello = 40'h4F4C4C4548;  // "HELLO", 'H' in the low byte
    for (int i = 0; i < NUM_REQ; i++) req_string[i*STR_W + STR_W - 8 +: 8] = 8'(8'hA0 + i);
    req_string[1*STR_W +: 40] = hello;

    // Reset values
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_pending", 64'(req_pending), 64'd0);
    check("rst_done", 64'(req_done), 64'd0);
    check("rst_tx_req", 64'(str_tx_req), 64'd0);
    check("rst_length", 64'(str_tx_length), 64'd0);
    check("rst_grant", 64'(grant_idx), 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);
    sys_rst = 1'b0;
    tick();

    // Single request, latency
    req_length[1*8 +: 8] = 8'd5;
    pulse(4'b0010);
    check("lat_pending", 64'(req_pending), 64'b0010);
    check("lat_no_req_c1", 64'(str_tx_req), 64'd0);
    tick();
    check("lat_req_c2", 64'(str_tx_req), 64'd1);
    check("hello_string", 64'(str_tx_string[39:0]), 64'(hello));
    serve(1, 5, 3, 4'b0000);

    // Simultaneous requests from rr=0
    do_reset();
    req_length = {8'd137, 8'd20, 8'd5, 8'd10};
    pulse(4'b1111);
    check("all_pending", 64'(req_pending), 64'b1111);
    serve(0, 10, 2, 4'b0000);
    serve(1, 5, 1, 4'b0000);
    serve(2, 20, 4, 4'b0000);
    serve(3, 137, 2, 4'b0000);

    // Fairness: 0 and 2 re-request on their own done
    pulse(4'b0101);
    serve(0, 10, 2, 4'b0001);
    serve(2, 20, 2, 4'b0100);
    serve(0, 10, 2, 4'b0000);
    serve(2, 20, 2, 4'b0000);
    check("fair_idle", 64'(req_pending), 64'd0);

    // Busy hold and length clamp
    req_length[3*8 +: 8] = 8'd200;
    str_tx_busy = 1'b1;
    pulse(4'b1000);
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (str_tx_req) seen = 1'b1;
    end
    check("busy_hold", 64'(seen), 64'd0);
    str_tx_busy = 1'b0;
    #1;
    check("busy_release", 64'(str_tx_req), 64'd1);
    serve(3, 137, 2, 4'b0000);

    // Set-wins and empty frame
    req_length[3*8 +: 8] = 8'd0;
    pulse(4'b1000);
    serve(3, 0, 2, 4'b1000);
    serve(3, 0, 1, 4'b0000);
    check("setwins_idle", 64'(req_pending), 64'd0);

    // Asynchronous reset mid WAIT_DONE
    pulse(4'b0010);
    n = 0;
    while (str_tx_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    tick();
    str_tx_busy = 1'b1;
    tick();
    check("pre_rst_grant", 64'(grant_idx), 64'd1);
    #2;
    sys_rst = 1'b1;
    #1;
    check("arst_pending", 64'(req_pending), 64'd0);
    check("arst_grant", 64'(grant_idx), 64'd0);
    check("arst_length", 64'(str_tx_length), 64'd0);
    check("arst_done", 64'(req_done), 64'd0);
    str_tx_busy = 1'b0;
    tick();
    sys_rst = 1'b0;
    tick();
    str_tx_done = 1'b1;
    tick();
    str_tx_done = 1'b0;
    #1;
    check("stray_done_ignored", 64'(req_done), 64'd0);

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog: no frame done, expiry 100 cycles after WAIT_DONE entry
    pulse(4'b0100);
    n = 0;
    while (str_tx_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    tick();
    str_tx_busy = 1'b1;
    repeat (99) tick();
    check("wd_early", 64'(timeout_err), 64'd0);
    tick();
    check("wd_fire", 64'(timeout_err), 64'd1);
    check("wd_done", 64'(req_done), 64'b0100);
    tick();
    str_tx_busy = 1'b0;
    check("wd_one_cycle", 64'(timeout_err), 64'd0);
    check("wd_pending", 64'(req_pending), 64'd0);
    str_tx_done = 1'b1;
    tick();
    str_tx_done = 1'b0;
    #1;
    check("wd_late_done", 64'(req_done), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
